// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
package reg_dump_pkg;

  localparam int NUM_REGS = 32;
  localparam int SEL_W    = 6;
  localparam logic [SEL_W-1:0] PC_SEL = 6'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/reg_dump.sv
// Walks the register bank one word at a time (x0..x31, then optionally the PC),
// snapshotting each word into an output register and handing it to a
// valid/ready consumer.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; sel parked at 0
//   READ  | sel = idx; bank output captured into dout at the closing edge
//   SEND  | dout_valid high, word held until the consumer takes it
//   DONE  | one-cycle done pulse, then back to IDLE
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int INCLUDE_PC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [SEL_W-1:0] sel,
  input  logic [31:0]      rdata,
  output logic [31:0]      dout,
  output logic [SEL_W-1:0] dout_idx,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
);

  // Last index walked; the PC sits just past x31 when it is included.
  localparam logic [SEL_W-1:0] LAST = (INCLUDE_PC != 0) ? PC_SEL : SEL_W'(NUM_REGS - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [31:0]      dout_q, dout_d;
  logic [SEL_W-1:0] dout_idx_q, dout_idx_d;

  // State, index and capture registers; reset wins over start and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      dout_q     <= '0;
      dout_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dout_q     <= dout_d;
      dout_idx_q <= dout_idx_d;
    end
  end

  // Next-state, capture and output decode; outputs depend only on registered state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dout_d     = dout_q;
    dout_idx_d = dout_idx_q;
    sel        = '0;
    dout_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          idx_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        sel        = idx_q;
        dout_d     = rdata;
        dout_idx_d = idx_q;
        state_d    = SEND;
      end
      SEND: begin
        sel        = idx_q;
        dout_valid = 1'b1;
        if (dout_ready) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dout     = dout_q;
  assign dout_idx = dout_idx_q;

endmodule
